rom_fetch_arbiter: RTL and testbench

//  Sequences and shares the asynchronous instruction ROM between two requesters.
//  - Fetch port (F_*): the core's instruction fetch.
//  - Debug/loader port (D_*): memory dump over the debug link.

---
 rtl/rom_fetch_arbiter.sv | 151 +++++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter
// Shares one asynchronous instruction ROM between the core's fetch port and a
// debug/loader port. The winning request's address is registered and driven to
// the ROM for one cycle. The ROM output is captured into a per-port data register
// at the next edge. This gives one read per cycle and a fixed two-cycle latency.
// Fetch has priority. Debug gets a forced turn after MAX_WAIT fetch grants made
// while debug was waiting.

module rom_fetch_arbiter #(
    parameter int TAM_POSICIONES = 1024,
    parameter int TAM_PALABRA    = 32,
    parameter int MAX_WAIT       = 4,
    localparam int AW            = $clog2(TAM_POSICIONES)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   F_REQ,
    input  logic [AW-1:0]          F_ADDR,
    output logic                   F_GNT,
    output logic                   F_VALID,
    output logic [TAM_PALABRA-1:0] F_DATA,
    input  logic                   D_REQ,
    input  logic [AW-1:0]          D_ADDR,
    output logic                   D_GNT,
    output logic                   D_VALID,
    output logic [TAM_PALABRA-1:0] D_DATA,
    output logic                   ROM_READ_EN,
    output logic [AW-1:0]          ROM_ADDR,
    input  logic [TAM_PALABRA-1:0] ROM_DATA,
    output logic                   ADDR_ERR,
    output logic                   BUSY
);

    // The address limit is one bit wider than AW, so that a power-of-2 depth can be represented.
    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(TAM_POSICIONES);
    localparam logic [3:0]  WAIT_MAX   = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ_F = 2'd1,
        ST_READ_D = 2'd2
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_addr_q;
    logic                   r_err_q;      // the latched address is out of range
    logic [3:0]             r_wait_cnt;
    logic                   r_f_gnt;
    logic                   r_d_gnt;
    logic                   r_f_valid;
    logic                   r_d_valid;
    logic [TAM_PALABRA-1:0] r_f_data;
    logic [TAM_PALABRA-1:0] r_d_data;
    logic                   r_rom_en;
    logic                   r_addr_err;
    logic                   r_busy;

    logic                   w_d_win;
    logic                   w_f_win;
    logic [AW-1:0]          w_win_addr;
    logic                   w_win_err;

    // Arbitration. Debug wins when fetch is idle, or when debug has waited through MAX_WAIT fetch grants.
    always_comb begin
        w_d_win    = D_REQ && (!F_REQ || (r_wait_cnt == WAIT_MAX));
        w_f_win    = F_REQ && !w_d_win;
        w_win_addr = w_d_win ? D_ADDR : F_ADDR;
        w_win_err  = ({1'b0, w_win_addr} >= ADDR_LIMIT);
    end

    // Sequencer. At each edge it captures the read that is closing and accepts the next winner.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_addr_q   <= '0;
            r_err_q    <= 1'b0;
            r_wait_cnt <= '0;
            r_f_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_f_valid  <= 1'b0;
            r_d_valid  <= 1'b0;
            r_f_data   <= '0;
            r_d_data   <= '0;
            r_rom_en   <= 1'b0;
            r_addr_err <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_f_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_f_valid  <= 1'b0;
            r_d_valid  <= 1'b0;
            r_addr_err <= 1'b0;

            // Close the read that is in flight. An out-of-range read returns zero.
            case (r_state)
                ST_READ_F: begin
                    r_f_data   <= r_err_q ? '0 : ROM_DATA;
                    r_f_valid  <= 1'b1;
                    r_addr_err <= r_err_q;
                end
                ST_READ_D: begin
                    r_d_data   <= r_err_q ? '0 : ROM_DATA;
                    r_d_valid  <= 1'b1;
                    r_addr_err <= r_err_q;
                end
                default: ;
            endcase

            // Accept the next request. ROM_READ_EN is suppressed for out-of-range addresses.
            if (w_d_win) begin
                r_state    <= ST_READ_D;
                r_addr_q   <= D_ADDR;
                r_err_q    <= w_win_err;
                r_d_gnt    <= 1'b1;
                r_busy     <= 1'b1;
                r_rom_en   <= !w_win_err;
                r_wait_cnt <= '0;
            end else if (w_f_win) begin
                r_state    <= ST_READ_F;
                r_addr_q   <= F_ADDR;
                r_err_q    <= w_win_err;
                r_f_gnt    <= 1'b1;
                r_busy     <= 1'b1;
                r_rom_en   <= !w_win_err;
                if (!D_REQ) begin
                    r_wait_cnt <= '0;
                end else if (r_wait_cnt != WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_state    <= ST_IDLE;
                r_err_q    <= 1'b0;
                r_busy     <= 1'b0;
                r_rom_en   <= 1'b0;
                r_wait_cnt <= '0;
            end
        end
    end

    assign F_GNT       = r_f_gnt;
    assign D_GNT       = r_d_gnt;
    assign F_VALID     = r_f_valid;
    assign D_VALID     = r_d_valid;
    assign F_DATA      = r_f_data;
    assign D_DATA      = r_d_data;
    assign ROM_READ_EN = r_rom_en;
    assign ROM_ADDR    = r_addr_q;
    assign ADDR_ERR    = r_addr_err;
    assign BUSY        = r_busy;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter. It has a ROM array and two queue-driven requesters.
// A transaction-level reference predicts the grant, ROM access and returned data
// for every cycle.

module tb_rom_fetch_arbiter;

    localparam int TAM = 1000;
    localparam int W   = 32;
    localparam int MW  = 4;
    localparam int AW  = 10;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          F_REQ, D_REQ;
    logic [AW-1:0] F_ADDR, D_ADDR;
    logic          F_GNT, D_GNT, F_VALID, D_VALID;
    logic [W-1:0]  F_DATA, D_DATA, ROM_DATA;
    logic          ROM_READ_EN, ADDR_ERR, BUSY;
    logic [AW-1:0] ROM_ADDR;

    logic [W-1:0]  rom [1024];

    int tests = 0;
    int fails = 0;

    // Pending addresses for each requester. The front entry is the request currently offered.
    int f_q[$];
    int d_q[$];

    // Reference state.
    int           streak;      // fetch grants in a row while debug was waiting
    int           prev_win;    // 0 none, 1 fetch, 2 debug: read now being returned
    int           prev_addr;
    int           last_addr;
    logic [W-1:0] f_data_m, d_data_m;
    string        glog;

    always #5 CLK = ~CLK;

    assign ROM_DATA = rom[ROM_ADDR];

    rom_fetch_arbiter #(
        .TAM_POSICIONES(TAM),
        .TAM_PALABRA   (W),
        .MAX_WAIT      (MW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .F_REQ      (F_REQ),
        .F_ADDR     (F_ADDR),
        .F_GNT      (F_GNT),
        .F_VALID    (F_VALID),
        .F_DATA     (F_DATA),
        .D_REQ      (D_REQ),
        .D_ADDR     (D_ADDR),
        .D_GNT      (D_GNT),
        .D_VALID    (D_VALID),
        .D_DATA     (D_DATA),
        .ROM_READ_EN(ROM_READ_EN),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .ADDR_ERR   (ADDR_ERR),
        .BUSY       (BUSY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each requester offers the front of its queue. When it has nothing to ask for, the address wanders.
    task automatic drive_reqs();
        F_REQ  = (f_q.size() > 0);
        F_ADDR = (f_q.size() > 0) ? AW'(f_q[0]) : AW'($urandom);
        D_REQ  = (d_q.size() > 0);
        D_ADDR = (d_q.size() > 0) ? AW'(d_q[0]) : AW'($urandom);
    endtask

    // Advance one clock. Predict the decision from the inputs seen at the edge, then check every output.
    task automatic step();
        int   win;
        int   waddr;
        logic rst_s;
        logic dreq_s;
        logic exp_err;
        rst_s  = RESET;
        dreq_s = D_REQ;
        win    = 0;
        waddr  = 0;
        if (!RESET) begin
            if (D_REQ && (!F_REQ || streak == MW)) begin
                win = 2; waddr = int'(D_ADDR);
            end else if (F_REQ) begin
                win = 1; waddr = int'(F_ADDR);
            end
        end
        @(posedge CLK);
        #1;
        if (rst_s) begin
            streak = 0; prev_win = 0; prev_addr = 0; last_addr = 0;
            f_data_m = '0; d_data_m = '0;
            f_q.delete(); d_q.delete();
            chk("rst_f_gnt",   F_GNT,       0);
            chk("rst_d_gnt",   D_GNT,       0);
            chk("rst_f_valid", F_VALID,     0);
            chk("rst_d_valid", D_VALID,     0);
            chk("rst_f_data",  F_DATA,      0);
            chk("rst_d_data",  D_DATA,      0);
            chk("rst_rom_en",  ROM_READ_EN, 0);
            chk("rst_rom_addr",ROM_ADDR,    0);
            chk("rst_addr_err",ADDR_ERR,    0);
            chk("rst_busy",    BUSY,        0);
        end else begin
            if (win == 2 || !dreq_s) streak = 0;
            else if (win == 1 && streak < MW) streak++;
            if (win != 0) last_addr = waddr;
            exp_err = (prev_win != 0) && (prev_addr >= TAM);
            if (prev_win == 1) f_data_m = (prev_addr < TAM) ? rom[prev_addr] : '0;
            if (prev_win == 2) d_data_m = (prev_addr < TAM) ? rom[prev_addr] : '0;
            chk("f_gnt",    F_GNT,       64'(win == 1));
            chk("d_gnt",    D_GNT,       64'(win == 2));
            chk("busy",     BUSY,        64'(win != 0));
            chk("rom_en",   ROM_READ_EN, 64'(win != 0 && waddr < TAM));
            chk("rom_addr", ROM_ADDR,    64'(last_addr));
            chk("f_valid",  F_VALID,     64'(prev_win == 1));
            chk("d_valid",  D_VALID,     64'(prev_win == 2));
            chk("f_data",   F_DATA,      64'(f_data_m));
            chk("d_data",   D_DATA,      64'(d_data_m));
            chk("addr_err", ADDR_ERR,    64'(exp_err));
            if (prev_win != 0)
                $display("[TB] %s read addr=%0d data=%08h err=%0d", (prev_win == 1) ? "F" : "D",
                         prev_addr, (prev_win == 1) ? F_DATA : D_DATA, ADDR_ERR);
            if (F_GNT) glog = {glog, "F"};
            if (D_GNT) glog = {glog, "D"};
            prev_win  = win;
            prev_addr = waddr;
            if (win == 1) void'(f_q.pop_front());
            if (win == 2) void'(d_q.pop_front());
        end
        drive_reqs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[1000] = 32'hDEAD_BEEF;   // data that must not leak out on a range error
        streak = 0; prev_win = 0; prev_addr = 0; last_addr = 0;
        f_data_m = '0; d_data_m = '0; glog = "";
        RESET = 1'b1;
        F_REQ = 1'b0; D_REQ = 1'b0; F_ADDR = '0; D_ADDR = '0;

        // Reset state.
        repeat (2) step();
        RESET = 1'b0;
        step();

        // Single fetch of word 5.
        f_q.push_back(5);
        drive_reqs();
        repeat (4) step();

        // Back-to-back fetch stream 0..3.
        f_q = '{0, 1, 2, 3};
        drive_reqs();
        repeat (7) step();

        // Both ports held. Debug forces its way in after MAX_WAIT fetch grants.
        glog = "";
        f_q = '{100, 101, 102, 103, 104, 105, 106, 107};
        d_q = '{16, 32};
        drive_reqs();
        repeat (14) step();
        tests++;
        assert (glog == "FFFFDFFFFD") else begin
            fails++;
            $error("FAIL grant_order: observed %s expected FFFFDFFFFD", glog);
        end

        // Debug alone: the last valid word, then an out-of-range address.
        d_q.push_back(TAM - 1);
        drive_reqs();
        repeat (4) step();
        d_q.push_back(1023);
        drive_reqs();
        repeat (4) step();

        // Reset while a fetch read is in flight. The read is dropped.
        f_q.push_back(7);
        drive_reqs();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        repeat (3) step();

        // Fetch at the first out-of-range address, and a mix around the boundary.
        f_q.push_back(TAM);
        drive_reqs();
        repeat (4) step();
        f_q = '{TAM - 1, TAM, 0};
        drive_reqs();
        repeat (6) step();

        // Random traffic with occasional resets.
        for (int b = 0; b < 40; b++) begin
            int nf, nd;
            nf = $urandom_range(0, 5);
            nd = $urandom_range(0, 4);
            for (int i = 0; i < nf; i++) f_q.push_back($urandom_range(0, 1023));
            for (int i = 0; i < nd; i++) d_q.push_back($urandom_range(0, 1023));
            drive_reqs();
            repeat ($urandom_range(1, 12)) step();
            if ($urandom_range(0, 19) == 0) begin
                RESET = 1'b1;
                step();
                RESET = 1'b0;
            end
        end
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
